// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-side hazard bus: ID/EX/MEM operand info, request channels and stall/bubble controls.
// master = pipeline / request sources, slave = hazard_ctrl_unit.
interface hazard_ctrl_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_REQ    = 2
);
  logic                  branch_id;
  logic                  jal_id;
  logic                  jalr_id;
  logic                  pc_src_id;
  logic [REG_ADDR_W-1:0] rs1_id;
  logic [REG_ADDR_W-1:0] rs2_id;
  logic                  rs1_used_id;
  logic                  rs2_used_id;
  logic [REG_ADDR_W-1:0] rd_ex;
  logic                  reg_write_ex;
  logic                  mem_read_ex;
  logic [REG_ADDR_W-1:0] rd_mem;
  logic                  mem_read_mem;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_done;
  logic [4:0]            stall;
  logic [4:0]            bubble;
  logic                  req_wait;
  logic                  timeout_err;

  modport master (
    output branch_id, jal_id, jalr_id, pc_src_id,
    output rs1_id, rs2_id, rs1_used_id, rs2_used_id,
    output rd_ex, reg_write_ex, mem_read_ex, rd_mem, mem_read_mem,
    output req_valid, req_done,
    input  stall, bubble, req_wait, timeout_err
  );

  modport slave (
    input  branch_id, jal_id, jalr_id, pc_src_id,
    input  rs1_id, rs2_id, rs1_used_id, rs2_used_id,
    input  rd_ex, reg_write_ex, mem_read_ex, rd_mem, mem_read_mem,
    input  req_valid, req_done,
    output stall, bubble, req_wait, timeout_err
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage core: load-use, ID branch dependency, redirect flush and request freeze.
// Optional HAZ_PERF_CNT_EN adds stall_cycles / flush_count performance counters.
//
// state    | meaning
// IDLE     | no request freeze in progress (a new request still freezes combinationally)
// REQ_WAIT | pipeline frozen on at least one pending request, wait_cnt running
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst,
  hazard_ctrl_unit_if.slave   hz
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         flush_count
`endif
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic {IDLE, REQ_WAIT} state_t;

  state_t             state;
  logic [NUM_REQ-1:0] pend_q;
  logic [CNT_W-1:0]   wait_cnt;
  logic               err_q;

  logic [NUM_REQ-1:0] pend;
  logic               any_pend;
  logic               timeout_hit;
  logic               freeze;
  logic               hit_ex;
  logic               hit_mem;
  logic               ctrl_id;
  logic               load_use;
  logic               br_dep;
  logic               redirect;
  logic [4:0]         stall_c;
  logic [4:0]         bubble_c;
  logic               wait_c;

  // A done pulse cancels its own channel in the same cycle, so valid&done never freezes.
  assign pend        = (pend_q | hz.req_valid) & ~hz.req_done;
  assign any_pend    = |pend;
  assign timeout_hit = (state == REQ_WAIT) && (wait_cnt == CNT_LAST);
  assign freeze      = any_pend & ~timeout_hit;

  assign hit_ex  = (hz.rd_ex != '0) &
                   ((hz.rs1_used_id & (hz.rs1_id == hz.rd_ex)) |
                    (hz.rs2_used_id & (hz.rs2_id == hz.rd_ex)));
  assign hit_mem = (hz.rd_mem != '0) &
                   ((hz.rs1_used_id & (hz.rs1_id == hz.rd_mem)) |
                    (hz.rs2_used_id & (hz.rs2_id == hz.rd_mem)));

  assign ctrl_id  = hz.branch_id | hz.jal_id | hz.jalr_id;
  assign load_use = hz.mem_read_ex & hit_ex;
  assign br_dep   = ctrl_id & ((hz.reg_write_ex & hit_ex) | (hz.mem_read_mem & hit_mem));
  assign redirect = ctrl_id & hz.pc_src_id;

  always_comb begin
    stall_c  = 5'b00000;
    bubble_c = 5'b00000;
    wait_c   = 1'b0;
    if (rst) begin
      if (freeze) begin
        stall_c = 5'b11111;
        wait_c  = 1'b1;
      end else if (load_use || br_dep) begin
        stall_c  = 5'b00011;
        bubble_c = 5'b00100;
      end else if (redirect) begin
        bubble_c = 5'b00001;
      end
    end
  end

  assign hz.stall       = stall_c;
  assign hz.bubble      = bubble_c;
  assign hz.req_wait    = wait_c;
  // The timeout is flagged in the very cycle the freeze is released.
  assign hz.timeout_err = err_q | (rst & timeout_hit);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      pend_q   <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pend_q   <= pend;
          wait_cnt <= '0;
          if (any_pend) state <= REQ_WAIT;
        end
        REQ_WAIT: begin
          if (timeout_hit) begin
            state    <= IDLE;
            pend_q   <= '0;
            wait_cnt <= '0;
            err_q    <= 1'b1;
          end else if (!any_pend) begin
            state    <= IDLE;
            pend_q   <= '0;
            wait_cnt <= '0;
          end else begin
            pend_q   <= pend;
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          pend_q   <= '0;
          wait_cnt <= '0;
        end
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (|stall_c)   stall_cycles <= stall_cycles + 32'd1;
      if (bubble_c[0]) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit (TIMEOUT_CYC=8): expected vectors queued per driven cycle,
// popped and compared mid-cycle against {stall, bubble, req_wait, timeout_err}.
module tb_hazard_ctrl_unit;
  localparam int RW = 5;
  localparam int NR = 2;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_unit_if #(.REG_ADDR_W(RW), .NUM_REQ(NR)) hz ();

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  hazard_ctrl_unit #(.REG_ADDR_W(RW), .NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .hz           (hz)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  typedef struct {
    string      tag;
    logic [11:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_val(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got stall=%b bubble=%b wait=%b terr=%b, want stall=%b bubble=%b wait=%b terr=%b",
               tag, obs[11:7], obs[6:2], obs[1], obs[0], exp[11:7], exp[6:2], exp[1], exp[0]);
    end
  endtask

  task automatic clr();
    hz.branch_id    = 1'b0;
    hz.jal_id       = 1'b0;
    hz.jalr_id      = 1'b0;
    hz.pc_src_id    = 1'b0;
    hz.rs1_id       = '0;
    hz.rs2_id       = '0;
    hz.rs1_used_id  = 1'b0;
    hz.rs2_used_id  = 1'b0;
    hz.rd_ex        = '0;
    hz.reg_write_ex = 1'b0;
    hz.mem_read_ex  = 1'b0;
    hz.rd_mem       = '0;
    hz.mem_read_mem = 1'b0;
    hz.req_valid    = '0;
    hz.req_done     = '0;
  endtask

  // Inputs are already driven for this cycle; queue the expectation, compare mid-cycle, advance.
  task automatic cyc(input string tag, input logic [4:0] s, input logic [4:0] b,
                     input logic w, input logic te);
    exp_t e;
    e.tag = tag;
    e.exp = {s, b, w, te};
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    check_val(e.tag, {hz.stall, hz.bubble, hz.req_wait, hz.timeout_err}, e.exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset forces outputs low even with hazards and requests present
    hz.mem_read_ex = 1'b1; hz.rd_ex = 5'd5; hz.rs1_id = 5'd5; hz.rs1_used_id = 1'b1;
    hz.req_valid = 2'b01;
    cyc("rst_force", 5'b00000, 5'b00000, 1'b0, 1'b0);
    clr(); rst = 1'b1;
    cyc("idle", 5'b00000, 5'b00000, 1'b0, 1'b0);

    // load-use
    hz.mem_read_ex = 1'b1; hz.rd_ex = 5'd5; hz.rs1_id = 5'd5; hz.rs1_used_id = 1'b1;
    cyc("ld_use_rs1", 5'b00011, 5'b00100, 1'b0, 1'b0);
    clr(); hz.rd_ex = 5'd5; hz.rs1_id = 5'd5; hz.rs1_used_id = 1'b1; hz.reg_write_ex = 1'b1;
    cyc("ld_use_gone", 5'b00000, 5'b00000, 1'b0, 1'b0);
    clr(); hz.mem_read_ex = 1'b1; hz.rd_ex = 5'd6; hz.rs2_id = 5'd6; hz.rs2_used_id = 1'b1;
    cyc("ld_use_rs2", 5'b00011, 5'b00100, 1'b0, 1'b0);
    hz.rs2_used_id = 1'b0;
    cyc("ld_unused", 5'b00000, 5'b00000, 1'b0, 1'b0);
    clr(); hz.mem_read_ex = 1'b1; hz.rd_ex = 5'd0; hz.rs1_id = 5'd0; hz.rs1_used_id = 1'b1;
    cyc("ld_x0", 5'b00000, 5'b00000, 1'b0, 1'b0);

    // branch / jump dependencies and redirect
    clr(); hz.branch_id = 1'b1; hz.rs2_id = 5'd7; hz.rs2_used_id = 1'b1;
    hz.rd_ex = 5'd7; hz.reg_write_ex = 1'b1;
    cyc("br_dep_ex", 5'b00011, 5'b00100, 1'b0, 1'b0);
    hz.reg_write_ex = 1'b0; hz.pc_src_id = 1'b1;
    cyc("br_redirect", 5'b00000, 5'b00001, 1'b0, 1'b0);
    clr(); hz.jalr_id = 1'b1; hz.rs1_id = 5'd9; hz.rs1_used_id = 1'b1;
    hz.rd_mem = 5'd9; hz.mem_read_mem = 1'b1; hz.pc_src_id = 1'b1;
    cyc("jalr_dep_mem", 5'b00011, 5'b00100, 1'b0, 1'b0);
    cyc("jalr_dep_rep", 5'b00011, 5'b00100, 1'b0, 1'b0);
    clr(); hz.jal_id = 1'b1; hz.pc_src_id = 1'b1;
    cyc("jal_redirect", 5'b00000, 5'b00001, 1'b0, 1'b0);
    clr(); hz.pc_src_id = 1'b1;
    cyc("pcsrc_no_ctrl", 5'b00000, 5'b00000, 1'b0, 1'b0);
    clr(); hz.branch_id = 1'b1; hz.rs1_id = 5'd0; hz.rs1_used_id = 1'b1;
    hz.rd_ex = 5'd0; hz.reg_write_ex = 1'b1;
    cyc("br_x0", 5'b00000, 5'b00000, 1'b0, 1'b0);
    clr(); hz.reg_write_ex = 1'b1; hz.rd_ex = 5'd3; hz.rs1_id = 5'd3; hz.rs1_used_id = 1'b1;
    cyc("alu_fwd", 5'b00000, 5'b00000, 1'b0, 1'b0);

    // channel 1: issued at t0, done at t0+5
    clr(); hz.req_valid = 2'b10;
    cyc("ch1_t0", 5'b11111, 5'b00000, 1'b1, 1'b0);
    clr(); hz.mem_read_ex = 1'b1; hz.rd_ex = 5'd5; hz.rs1_id = 5'd5; hz.rs1_used_id = 1'b1;
    cyc("ch1_prio", 5'b11111, 5'b00000, 1'b1, 1'b0);
    clr();
    for (int i = 0; i < 3; i++) cyc("ch1_hold", 5'b11111, 5'b00000, 1'b1, 1'b0);
    hz.req_done = 2'b10;
    cyc("ch1_done", 5'b00000, 5'b00000, 1'b0, 1'b0);
    clr();
    cyc("ch1_after", 5'b00000, 5'b00000, 1'b0, 1'b0);

    // zero-cycle completion
    hz.req_valid = 2'b01; hz.req_done = 2'b01;
    cyc("ch0_zero", 5'b00000, 5'b00000, 1'b0, 1'b0);
    clr();
    cyc("ch0_zero_next", 5'b00000, 5'b00000, 1'b0, 1'b0);

    // both channels, done at t+2 and t+4
    hz.req_valid = 2'b11;
    cyc("both_t0", 5'b11111, 5'b00000, 1'b1, 1'b0);
    clr();
    cyc("both_t1", 5'b11111, 5'b00000, 1'b1, 1'b0);
    hz.req_done = 2'b01;
    cyc("both_t2", 5'b11111, 5'b00000, 1'b1, 1'b0);
    clr();
    cyc("both_t3", 5'b11111, 5'b00000, 1'b1, 1'b0);
    hz.req_done = 2'b10;
    cyc("both_t4", 5'b00000, 5'b00000, 1'b0, 1'b0);
    clr();
    cyc("both_t5", 5'b00000, 5'b00000, 1'b0, 1'b0);

    // reset in the middle of a wait
    hz.req_valid = 2'b01;
    cyc("rw_t0", 5'b11111, 5'b00000, 1'b1, 1'b0);
    clr();
    cyc("rw_t1", 5'b11111, 5'b00000, 1'b1, 1'b0);
    rst = 1'b0;
    cyc("rst_mid", 5'b00000, 5'b00000, 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) cyc("rst_after", 5'b00000, 5'b00000, 1'b0, 1'b0);

    // watchdog timeout with no done
    hz.req_valid = 2'b01;
    cyc("to_stall0", 5'b11111, 5'b00000, 1'b1, 1'b0);
    clr();
    for (int i = 1; i < TO; i++) cyc("to_stall", 5'b11111, 5'b00000, 1'b1, 1'b0);
    cyc("to_hit", 5'b00000, 5'b00000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc("to_sticky", 5'b00000, 5'b00000, 1'b0, 1'b1);
    hz.req_valid = 2'b10;
    cyc("to_new_req", 5'b11111, 5'b00000, 1'b1, 1'b1);
    clr(); hz.req_done = 2'b10;
    cyc("to_new_done", 5'b00000, 5'b00000, 1'b0, 1'b1);
    clr();
    cyc("to_final", 5'b00000, 5'b00000, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench time limit reached, got no end, want end");
    $fatal(1, "time limit");
  end
endmodule
